// File: rtl/trace_pkg.sv
// Shared definitions for the register trace stage: record layout, byte framing
// and serializer state encoding.
package trace_pkg;

  localparam logic [7:0] TRACE_HEADER = 8'hA5;
  localparam int         REC_W        = 32;
  localparam int         REC_BYTES    = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef struct packed {
    logic [7:0] stamp;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
  } trace_rec_t;

  // Byte idx of a framed record: 0 is the sync header, 1..4 the record fields.
  function automatic logic [7:0] rec_byte(input logic [7:0] hdr,
                                          input trace_rec_t rec,
                                          input logic [2:0] idx);
    logic [7:0] b;
    b = hdr;
    case (idx)
      3'd1:    b = rec.stamp;
      3'd2:    b = rec.r0;
      3'd3:    b = rec.r1;
      3'd4:    b = rec.r2;
      default: b = hdr;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy level; the head word is
// visible combinationally so a pop can load it on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_level    = r_level;

endmodule

// File: rtl/reg_trace.sv
// Register trace: stamps every cycle in which R0/R1/R2 change, buffers the
// records and streams them out as framed 5-byte packets.
module reg_trace
  import trace_pkg::*;
#(
  parameter int         DEPTH  = 8,
  parameter logic [7:0] HEADER = TRACE_HEADER
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [7:0]                 debug_r0,
  input  logic [7:0]                 debug_r1,
  input  logic [7:0]                 debug_r2,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  logic [7:0]       r_stamp;
  logic [23:0]      r_snap;
  logic             r_snap_valid;
  logic             r_overflow;
  logic [7:0]       r_drop_count;
  logic [0:0]       r_state;
  logic [2:0]       r_idx;
  trace_rec_t       r_shift;

  logic [23:0]      w_regs;
  logic             w_trigger;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_drop;
  logic             w_last;
  logic             w_pop;
  logic [REC_W-1:0] w_head;

  assign w_regs    = {debug_r0, debug_r1, debug_r2};
  assign w_trigger = enable && (!r_snap_valid || (w_regs != r_snap));
  assign w_push    = w_trigger && !w_full;
  assign w_drop    = w_trigger && w_full;

  // Final byte accepted: the next record may be loaded on this same edge.
  assign w_last = (r_state == ST_SEND) && out_ready && (r_idx == 3'(REC_BYTES-1));
  assign w_pop  = !w_empty && ((r_state == ST_IDLE) || w_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stamp      <= '0;
      r_snap       <= '0;
      r_snap_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_stamp <= r_stamp + 8'd1;
      if (w_trigger) begin
        r_snap       <= w_regs;
        r_snap_valid <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({r_stamp, debug_r0, debug_r1, debug_r2}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_shift <= '0;
    end else if (w_pop) begin
      r_shift <= trace_rec_t'(w_head);
      r_idx   <= '0;
      r_state <= ST_SEND;
    end else if ((r_state == ST_SEND) && out_ready) begin
      if (r_idx == 3'(REC_BYTES-1)) begin
        r_state <= ST_IDLE;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  assign out_valid  = (r_state == ST_SEND);
  assign out_data   = out_valid ? rec_byte(HEADER, r_shift, r_idx) : 8'h00;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_reg_trace.sv
// Randomized bench for reg_trace: a transaction-level reference model predicts
// the byte stream into a scoreboard queue; a monitor checks every handshake.
module tb_reg_trace;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [7:0]    r0 = '0, r1 = '0, r2 = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          overflow;
  logic [7:0]    drop_count;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  reg_trace #(.DEPTH(DEPTH), .HEADER(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .debug_r0   (r0),
    .debug_r1   (r1),
    .debug_r2   (r2),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .overflow   (overflow),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: records counted in a FIFO of occupancy m_cnt; m_left is
  // the number of bytes of the record currently being sent (0 = none).
  int          m_cycle;
  int          m_cnt;
  int          m_left;
  bit          m_snap_ok;
  logic [23:0] m_snap;
  bit          m_ovf;
  int          m_drops;
  logic [7:0]  exp_bytes[$];

  always @(posedge clk) begin
    if (!rst) begin
      bit trig;
      bit full;
      bit empty;
      full  = (m_cnt == DEPTH);
      empty = (m_cnt == 0);
      trig  = enable && (!m_snap_ok || ({r0, r1, r2} != m_snap));
      if (m_left == 0) begin
        if (!empty) begin m_cnt--; m_left = 5; end
      end else if (out_ready) begin
        m_left--;
        if (m_left == 0 && !empty) begin m_cnt--; m_left = 5; end
      end
      if (trig) begin
        m_snap    = {r0, r1, r2};
        m_snap_ok = 1;
        if (full) begin
          m_ovf   = 1;
          m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        end else begin
          m_cnt++;
          exp_bytes.push_back(8'hA5);
          exp_bytes.push_back(8'(m_cycle % 256));
          exp_bytes.push_back(r0);
          exp_bytes.push_back(r1);
          exp_bytes.push_back(r2);
        end
      end
      m_cycle++;
    end
  end

  // Monitor
  bit         prev_hold;
  logic [7:0] prev_data;
  int         rx_idx;
  logic [7:0] rx_rec [5];
  int         rx_records;

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", int'(out_valid), int'(m_left != 0));
      chk("fifo_level", int'(fifo_level), m_cnt);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("drop_count", int'(drop_count), m_drops);
      if (prev_hold) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_bytes.size() == 0) begin
          chk("unexpected_byte", int'(out_data), -1);
        end else begin
          logic [7:0] e;
          e = exp_bytes.pop_front();
          chk("byte", int'(out_data), int'(e));
        end
        rx_rec[rx_idx] = out_data;
        rx_idx++;
        if (rx_idx == 5) begin
          rx_idx = 0;
          rx_records++;
          $display("record %0d: %02h %02h %02h %02h %02h", rx_records,
                   rx_rec[0], rx_rec[1], rx_rec[2], rx_rec[3], rx_rec[4]);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    m_cycle = 0; m_cnt = 0; m_left = 0; m_snap_ok = 0; m_snap = '0;
    m_ovf = 0; m_drops = 0; exp_bytes.delete();
    prev_hold = 0; rx_idx = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((m_cnt != 0 || m_left != 0) && n < 400) begin tick(); n++; end
    chk(name, int'(m_cnt != 0 || m_left != 0), 0);
    tick();
  endtask

  initial begin
    int n;
    // First sample and change after idle
    r0 = 0; r1 = 0; r2 = 0; enable = 1; out_ready = 1;
    apply_reset();
    tick();
    chk("latency_edge1_valid", int'(out_valid), 0);
    tick();
    chk("latency_edge2_valid", int'(out_valid), 1);
    while (m_cycle < 7) tick();
    r1 = 8'd3;
    repeat (20) tick();
    chk("idle_no_bytes", exp_bytes.size(), 0);

    // Backpressure mid-record
    r0 = 8'h11;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("bp_wait_valid", int'(out_valid), 1);
    tick(); tick();
    out_ready = 0;
    repeat (10) tick();
    drain("bp_drain");

    // Randomized traffic
    repeat (400) begin
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) r0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r2 = 8'($urandom);
      tick();
    end
    enable = 1;
    drain("rand_drain");

    // Overflow, then saturation of drop_count
    apply_reset();
    out_ready = 0;
    repeat (DEPTH + 3) begin r0 = r0 + 8'd1; tick(); end
    chk("ovf_level_full", int'(fifo_level), DEPTH);
    chk("ovf_sticky", int'(overflow), 1);
    repeat (260) begin r0 = r0 + 8'd1; tick(); end
    chk("drop_saturated", int'(drop_count), 255);
    drain("ovf_drain");

    // Enable gating across stamp wrap
    enable = 0;
    repeat (300) begin r2 = ~r2; tick(); end
    chk("gated_no_records", exp_bytes.size(), 0);
    enable = 1;
    repeat (10) tick();
    drain("gate_drain");

    // Reset in the middle of a record
    r1 = r1 + 8'd5;
    n = 0;
    while (m_left != 3 && n < 50) begin tick(); n++; end
    chk("mid_record_reached", m_left, 3);
    apply_reset();
    repeat (12) tick();
    drain("final_drain");
    chk("scoreboard_empty", exp_bytes.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
